// File: rtl/mem_arb_defs.sv
// Shared definitions for the two-master block-RAM arbiter: state codes, master
// IDs, the write/read payload bundle and the request decode.
package mem_arb_defs;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BE_WIDTH   = 4;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_GRANT0 = 2'd1;
  localparam logic [1:0] ARB_GRANT1 = 2'd2;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]   we;
    logic                  re;
  } xfer_t;

  // A master is requesting when any read or write strobe is up.
  function automatic logic has_req(input xfer_t x);
    return x.re | (|x.we);
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Per-grant cycle counter; expire flags the last allowed cycle of a grant.
// TIMEOUT_CYCLES = 0 removes the counter and never expires.
module arb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  if (TIMEOUT_CYCLES == 0) begin : g_disabled
    assign expire = 1'b0;
  end else begin : g_enabled
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
      if (reset || clear) begin
        count <= '0;
      end else if (enable) begin
        count <= count + CW'(1);
      end
    end

    assign expire = (count == CW'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/mem_arbiter_2to1.sv
// Two-master arbiter for the shared BRAM data port (M0 = CPU data, M1 = boot/DMA),
// XUM hold-until-Ack handshake, round-robin or fixed priority, per-grant timeout.
module mem_arbiter_2to1
  import mem_arb_defs::*;
#(
  parameter int unsigned ADDR_WIDTH     = 30,
  parameter int unsigned FIXED_PRIORITY = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] M0_Address,
  input  logic [DATA_WIDTH-1:0] M0_DataIn,
  input  logic [BE_WIDTH-1:0]   M0_WriteEnable,
  input  logic                  M0_ReadEnable,
  output logic [DATA_WIDTH-1:0] M0_DataOut,
  output logic                  M0_Ack,
  input  logic [ADDR_WIDTH-1:0] M1_Address,
  input  logic [DATA_WIDTH-1:0] M1_DataIn,
  input  logic [BE_WIDTH-1:0]   M1_WriteEnable,
  input  logic                  M1_ReadEnable,
  output logic [DATA_WIDTH-1:0] M1_DataOut,
  output logic                  M1_Ack,
  output logic [ADDR_WIDTH-1:0] S_Address,
  output logic [DATA_WIDTH-1:0] S_DataOut,
  output logic [BE_WIDTH-1:0]   S_WriteEnable,
  output logic                  S_ReadEnable,
  input  logic [DATA_WIDTH-1:0] S_DataIn,
  input  logic                  S_Ack,
  output logic                  Busy,
  output logic                  Timeout_Err
);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  last_grant;
  logic                  last_grant_nxt;
  xfer_t                 m0_xfer;
  xfer_t                 m1_xfer;
  xfer_t                 sel_xfer;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  m0_req;
  logic                  m1_req;
  logic                  sel_req;
  logic                  sel;
  logic                  granted;
  logic                  expire;
  logic                  timeout;

  assign m0_xfer  = '{data: M0_DataIn, we: M0_WriteEnable, re: M0_ReadEnable};
  assign m1_xfer  = '{data: M1_DataIn, we: M1_WriteEnable, re: M1_ReadEnable};
  assign m0_req   = has_req(m0_xfer);
  assign m1_req   = has_req(m1_xfer);

  assign granted  = (state != ARB_IDLE);
  assign sel      = (state == ARB_GRANT1) ? MASTER1 : MASTER0;
  assign sel_xfer = (sel == MASTER1) ? m1_xfer : m0_xfer;
  assign sel_addr = (sel == MASTER1) ? M1_Address : M0_Address;
  assign sel_req  = (sel == MASTER1) ? m1_req : m0_req;

  // A slave Ack in the expiry cycle wins; a dropped request is an abort, not a timeout.
  assign timeout  = granted & sel_req & expire & ~S_Ack;

  arb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (~granted),
    .enable (granted & ~S_Ack),
    .expire (expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= MASTER1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      ARB_IDLE: begin
        if (m0_req && (!m1_req || FIXED_PRIORITY != 0 || last_grant == MASTER1)) begin
          state_nxt      = ARB_GRANT0;
          last_grant_nxt = MASTER0;
        end else if (m1_req) begin
          state_nxt      = ARB_GRANT1;
          last_grant_nxt = MASTER1;
        end
      end
      ARB_GRANT0, ARB_GRANT1: begin
        if (S_Ack || !sel_req || timeout) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Slave strobes follow the granted master's request within the same cycle.
  always_comb begin
    S_Address     = '0;
    S_DataOut     = ZERO_DATA;
    S_WriteEnable = '0;
    S_ReadEnable  = 1'b0;
    M0_DataOut    = ZERO_DATA;
    M1_DataOut    = ZERO_DATA;
    M0_Ack        = 1'b0;
    M1_Ack        = 1'b0;
    if (granted) begin
      if (sel_req) begin
        S_Address     = sel_addr;
        S_DataOut     = sel_xfer.data;
        S_WriteEnable = sel_xfer.we;
        S_ReadEnable  = sel_xfer.re;
      end
      if (sel == MASTER0) begin
        M0_DataOut = timeout ? ZERO_DATA : S_DataIn;
        M0_Ack     = S_Ack | timeout;
      end else begin
        M1_DataOut = timeout ? ZERO_DATA : S_DataIn;
        M1_Ack     = S_Ack | timeout;
      end
    end
  end

  assign Busy        = granted;
  assign Timeout_Err = timeout;

endmodule
